// File: rtl/text_buffer_writer.sv
// Character-cell text buffer writer: fills the 16x16 grid read by the
// character-overlay renderer. Accepts an ASCII stream, tracks a write cursor,
// interprets CR/LF/BS/FF and clears the screen after reset or form feed.
module text_buffer_writer #(
  parameter logic [7:0] CLEAR_CHAR = 8'h20,
  parameter int         COLS       = 16,
  parameter int         ROWS       = 16
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       cursor_set,
  input  logic [7:0] cursor_in,
  input  logic [7:0] text_xy,
  output logic [6:0] char_code,
  output logic [7:0] cursor_xy,
  output logic       busy
);

  // Address is {row[3:0], col[3:0]}, so the grid is fixed at 256 cells.
  localparam int         CELLS = COLS * ROWS;
  localparam logic [7:0] LAST  = 8'(CELLS - 1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [0:0] {CLEAR, IDLE} state_t;

  state_t     state_q, state_d;
  logic [7:0] clr_addr, clr_d;
  logic [7:0] cur_d;
  logic       we;
  logic [7:0] waddr;
  logic [6:0] wdata;
  logic       accept;

  logic [6:0] mem [CELLS];

  // Next-state, cursor update and single write-port steering.
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_addr;
    cur_d    = cursor_xy;
    we       = 1'b0;
    waddr    = clr_addr;
    wdata    = CLEAR_CHAR[6:0];
    wr_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    case (state_q)
      CLEAR: begin
        busy  = 1'b1;
        we    = 1'b1;
        clr_d = clr_addr + 8'd1;
        if (clr_addr == LAST) state_d = IDLE;
      end
      IDLE: begin
        // cursor_set wins; the producer must hold its char until it drops.
        wr_ready = !cursor_set && !rst;
        accept   = wr_valid && wr_ready;
        if (cursor_set) begin
          cur_d = cursor_in;
        end else if (accept) begin
          if (wr_char >= 8'h20 && wr_char <= 8'h7E) begin
            we    = 1'b1;
            waddr = cursor_xy;
            wdata = wr_char[6:0];
            cur_d = cursor_xy + 8'd1;
          end else begin
            case (wr_char)
              CH_CR: cur_d = {cursor_xy[7:4], 4'd0};
              CH_LF: cur_d = {cursor_xy[7:4] + 4'd1, 4'd0};
              CH_BS: cur_d = (cursor_xy != 8'd0) ? cursor_xy - 8'd1 : 8'd0;
              CH_FF: begin
                cur_d   = 8'd0;
                clr_d   = 8'd0;
                state_d = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // State, clear pointer and cursor; reset restarts a full clear.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_addr  <= 8'd0;
      cursor_xy <= 8'd0;
    end else begin
      state_q   <= state_d;
      clr_addr  <= clr_d;
      cursor_xy <= cur_d;
    end
  end

  // Cell memory write port.
  always_ff @(posedge pclk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Renderer read port: 1-cycle latency, old data on same-address write.
  always_ff @(posedge pclk) begin
    if (rst) char_code <= 7'd0;
    else     char_code <= mem[text_xy];
  end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Bench for text_buffer_writer: directed scenarios plus a random stream,
// checked against a screen/cursor model built from row/col arithmetic.
module tb_text_buffer_writer;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_char = 8'h00;
  logic       cursor_set = 1'b0;
  logic [7:0] cursor_in = 8'h00;
  logic [7:0] text_xy = 8'h00;
  logic [6:0] char_code;
  logic [7:0] cursor_xy;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [6:0] m_mem [256];
  logic [7:0] m_cur;

  always #5 pclk = ~pclk;

  text_buffer_writer dut (
    .pclk(pclk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_char(wr_char), .cursor_set(cursor_set), .cursor_in(cursor_in),
    .text_xy(text_xy), .char_code(char_code), .cursor_xy(cursor_xy),
    .busy(busy)
  );

  function automatic void model_clear();
    for (int i = 0; i < 256; i++) m_mem[i] = 7'h20;
  endfunction

  function automatic void model_apply(input logic [7:0] c);
    int row;
    row = int'(m_cur) / 16;
    if (c >= 8'h20 && c <= 8'h7E) begin
      m_mem[m_cur] = c[6:0];
      m_cur = 8'((int'(m_cur) + 1) % 256);
    end else if (c == 8'h0D) begin
      m_cur = 8'(row * 16);
    end else if (c == 8'h0A) begin
      m_cur = 8'(((row + 1) % 16) * 16);
    end else if (c == 8'h08) begin
      if (m_cur != 8'h00) m_cur = m_cur - 8'h01;
    end else if (c == 8'h0C) begin
      m_cur = 8'h00;
      model_clear();
    end
  endfunction

  task automatic send(input logic [7:0] c, input string nm);
    wr_valid = 1'b1;
    wr_char  = c;
    @(negedge pclk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready got %b expected 1", nm, wr_ready);
    end
    @(posedge pclk); #1;
    wr_valid = 1'b0;
    model_apply(c);
    checks++;
    if (cursor_xy !== m_cur) begin
      errors++;
      $display("FAIL %s_cursor got %h expected %h", nm, cursor_xy, m_cur);
    end
  endtask

  task automatic set_cursor(input logic [7:0] v, input string nm);
    cursor_set = 1'b1;
    cursor_in  = v;
    @(negedge pclk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_setready got %b expected 0", nm, wr_ready);
    end
    @(posedge pclk); #1;
    cursor_set = 1'b0;
    m_cur = v;
    checks++;
    if (cursor_xy !== m_cur) begin
      errors++;
      $display("FAIL %s_setcursor got %h expected %h", nm, cursor_xy, m_cur);
    end
  endtask

  task automatic read_chk(input logic [7:0] a, input string nm);
    text_xy = a;
    @(posedge pclk); #1;
    checks++;
    if (char_code !== m_mem[a]) begin
      errors++;
      $display("FAIL %s_read[%h] got %h expected %h", nm, a, char_code, m_mem[a]);
    end
  endtask

  // Counts busy cycles from now until IDLE; ends on the first idle negedge.
  task automatic wait_idle(input string nm);
    int n   = 0;
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge pclk);
      if (busy !== 1'b1) break;
      n++;
      if (wr_ready !== 1'b0) bad++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL %s_busy_cycles got %0d expected 256", nm, n);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_ready_in_clear got %0d cycles expected 0", nm, bad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge pclk);
    #1;
    checks++;
    if (char_code !== 7'h00 || cursor_xy !== 8'h00 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got code=%h cur=%h rdy=%b busy=%b expected 00 00 0 1",
               char_code, cursor_xy, wr_ready, busy);
    end
    rst = 1'b0;
    m_cur = 8'h00;
    model_clear();
    wait_idle("reset");
    @(posedge pclk); #1;
    read_chk(8'h00, "reset");
    read_chk(8'h7F, "reset");
    read_chk(8'hFF, "reset");
  endtask

  task automatic test_stream();
    send(8'h41, "stream_A");
    send(8'h42, "stream_B");
    checks++;
    if (cursor_xy !== 8'h02) begin
      errors++;
      $display("FAIL stream_cursor got %h expected 02", cursor_xy);
    end
    read_chk(8'h00, "stream");
    read_chk(8'h01, "stream");
  endtask

  task automatic test_control();
    set_cursor(8'h35, "ctl");
    send(8'h0D, "ctl_cr");
    checks++;
    if (cursor_xy !== 8'h30) begin
      errors++;
      $display("FAIL ctl_cr_const got %h expected 30", cursor_xy);
    end
    send(8'h0A, "ctl_lf");
    checks++;
    if (cursor_xy !== 8'h40) begin
      errors++;
      $display("FAIL ctl_lf_const got %h expected 40", cursor_xy);
    end
    set_cursor(8'hF7, "ctl");
    send(8'h0A, "ctl_lfwrap");
    send(8'h08, "ctl_bs0");
    checks++;
    if (cursor_xy !== 8'h00) begin
      errors++;
      $display("FAIL ctl_bs0_const got %h expected 00", cursor_xy);
    end
  endtask

  task automatic test_wrap();
    set_cursor(8'hFF, "wrap");
    send(8'h5A, "wrap_Z");
    checks++;
    if (cursor_xy !== 8'h00) begin
      errors++;
      $display("FAIL wrap_cursor got %h expected 00", cursor_xy);
    end
    read_chk(8'hFF, "wrap");
  endtask

  task automatic test_priority();
    logic [6:0] old;
    text_xy    = 8'h10;
    cursor_set = 1'b1;
    cursor_in  = 8'h10;
    wr_valid   = 1'b1;
    wr_char    = 8'h51;
    @(negedge pclk);
    checks++;
    if (wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready got %b expected 0", wr_ready);
    end
    @(posedge pclk); #1;
    cursor_set = 1'b0;
    m_cur = 8'h10;
    old = m_mem[8'h10];
    checks++;
    if (cursor_xy !== 8'h10) begin
      errors++;
      $display("FAIL prio_cursor got %h expected 10", cursor_xy);
    end
    @(negedge pclk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL prio_ready_after got %b expected 1", wr_ready);
    end
    @(posedge pclk); #1;
    wr_valid = 1'b0;
    // Read sampled on the same edge as the 'Q' write: old data expected.
    checks++;
    if (char_code !== old) begin
      errors++;
      $display("FAIL prio_rdw got %h expected %h", char_code, old);
    end
    model_apply(8'h51);
    @(posedge pclk); #1;
    checks++;
    if (char_code !== 7'h51) begin
      errors++;
      $display("FAIL prio_Q got %h expected 51", char_code);
    end
    send(8'h01, "ignore_01");
    read_chk(m_cur, "ignore");
  endtask

  task automatic test_ff();
    int bad = 0;
    set_cursor(8'h00, "ff");
    send(8'h61, "ff_fill");
    send(8'h62, "ff_fill");
    send(8'h63, "ff_fill");
    send(8'h64, "ff_fill");
    send(8'h0C, "ff");
    wr_valid = 1'b1;
    wr_char  = 8'h58;
    wait_idle("ff");
    checks++;
    if (cursor_xy !== 8'h00 || wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ff_idle got cur=%h rdy=%b expected 00 1", cursor_xy, wr_ready);
    end
    @(posedge pclk); #1;
    wr_valid = 1'b0;
    model_apply(8'h58);
    checks++;
    if (cursor_xy !== m_cur) begin
      errors++;
      $display("FAIL ff_held_char_cursor got %h expected %h", cursor_xy, m_cur);
    end
    read_chk(8'h00, "ff");
    for (int a = 1; a < 256; a++) begin
      text_xy = 8'(a);
      @(posedge pclk); #1;
      if (char_code !== 7'h20) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL ff_cleared got %0d bad cells expected 0", bad);
    end
  endtask

  task automatic test_rst_mid_clear();
    send(8'h0C, "rstmid_ff");
    repeat (100) @(posedge pclk);
    #1;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got %b expected 1", busy);
    end
    rst = 1'b1;
    @(posedge pclk); #1;
    checks++;
    if (wr_ready !== 1'b0 || cursor_xy !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_state got rdy=%b cur=%h expected 0 00", wr_ready, cursor_xy);
    end
    rst = 1'b0;
    m_cur = 8'h00;
    model_clear();
    wait_idle("rstmid");
    @(posedge pclk); #1;
    read_chk(8'h00, "rstmid");
    read_chk(8'hFF, "rstmid");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2, 3, 4: send(8'($urandom_range(32, 126)), "rnd_print");
        5: send(8'h0D, "rnd_cr");
        6: send(8'h0A, "rnd_lf");
        7: send(8'h08, "rnd_bs");
        8: set_cursor(8'($urandom), "rnd");
        default: send(8'($urandom_range(127, 255)), "rnd_other");
      endcase
      if (i % 8 == 0) read_chk(8'($urandom), "rnd");
    end
    for (int i = 0; i < 32; i++) read_chk(8'($urandom), "rnd_end");
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    m_cur = 8'h00;
    model_clear();
    test_reset();
    test_stream();
    test_control();
    test_wrap();
    test_priority();
    test_ff();
    test_rst_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_buffer_writer.md
Name: text_buffer_writer

Overview:
- Character-cell text buffer: the producer side that fills the 16x16 character grid scanned by the character-overlay renderer.
- Accepts an ASCII stream over a valid/ready handshake, maintains a write cursor, interprets CR/LF/BS/FF control codes and clears the screen.
- Serves the renderer's read port: 8-bit cell address (row*16 + col) in, 7-bit character code out.
- Sits between the measurement/formatting logic and the font-ROM/overlay pipeline.

Parameters:
- CLEAR_CHAR, 8'h20: code written to every cell on clear.
- COLS, 16: cells per row. Fixed, because the address is {row[3:0], col[3:0]}.
- ROWS, 16: rows. Fixed for the same reason.

Ports:
- pclk, input, 1: pixel clock.
- rst, input, 1: reset, synchronous, active-high.
- wr_valid, input, 1: wr_char is presented.
- wr_ready, output, 1: block can accept wr_char this cycle.
- wr_char, input, 8: ASCII code or control code.
- cursor_set, input, 1: load the cursor from cursor_in.
- cursor_in, input, 8: new cursor address {row, col}.
- text_xy, input, 8: read address from the renderer.
- char_code, output, 7: character at text_xy, registered.
- cursor_xy, output, 8: current cursor address.
- busy, output, 1: clear in progress.

Behaviour:
- Storage:
  - 256 x 7-bit dual-port memory. Write port is driven by the FSM; read port is driven by text_xy.
  - Stored value is wr_char[6:0].
- Read port:
  - char_code <= mem[text_xy] every cycle. Latency is 1 cycle, and the read port ignores the FSM state.
  - A read and a write to the same address in the same cycle returns the old data.
  - rst forces char_code to 0 for the reset cycle.
- FSM states: CLEAR, IDLE.
- Reset:
  - rst puts the FSM in CLEAR with clr_addr=0, cursor_xy=0, busy=1, wr_ready=0.
  - rst asserted mid-clear or mid-stream restarts the clear from address 0.
- CLEAR state:
  - Each cycle: write CLEAR_CHAR[6:0] to mem[clr_addr], then clr_addr+1.
  - After writing address 255, move to IDLE next cycle. A full clear takes 256 cycles with busy=1.
  - wr_valid and cursor_set are ignored during CLEAR.
- IDLE state:
  - busy=0.
  - wr_ready = !cursor_set (combinational).
  - A transfer occurs when wr_valid && wr_ready.
- cursor_set in IDLE: cursor_xy <= cursor_in. It takes priority over a simultaneous char, which is not accepted (wr_ready=0) and must be held by the producer.
- Accepted wr_char decode:
  - 0x20..0x7E (printable): mem[cursor_xy] <= wr_char[6:0]; cursor_xy <= cursor_xy+1, wrapping 8-bit (255 -> 0, i.e. bottom-right to top-left). Col 15 -> next row col 0 follows naturally.
  - 0x0D (CR): col <= 0, row unchanged.
  - 0x0A (LF): row <= row+1, wrapping 15 -> 0; col <= 0.
  - 0x08 (BS): if cursor_xy != 0 then cursor_xy-1, else stays 0. No memory write.
  - 0x0C (FF): cursor_xy <= 0; go to CLEAR (256 cycles, busy=1).
  - Any other code: accepted (handshake completes) with no effect.
- No scrolling; only one character is accepted per cycle.
- wr_ready is 0 in CLEAR and during the reset cycle.

Test Plan:
- Reset clear:
  - Stimulus: rst high 1 cycle, then release.
  - Required: busy=1 and wr_ready=0 for exactly 256 cycles. Afterwards, reading text_xy=0x00, 0x7F, 0xFF returns 7'h20 one cycle after the address is applied.
- Stream write:
  - Stimulus: send 'A','B' (0x41, 0x42) back-to-back.
  - Required: mem[0]=0x41, mem[1]=0x42, cursor_xy=0x02. A read at text_xy=0x01 returns 0x42 with 1-cycle latency.
- Control codes:
  - Stimulus: cursor_set to 0x35, send CR.
  - Required: cursor_xy=0x30.
  - Stimulus: send LF.
  - Required: cursor_xy=0x40.
  - Stimulus: cursor_set 0xF7, send LF.
  - Required: cursor_xy=0x00.
  - Stimulus: send BS at 0x00.
  - Required: cursor_xy stays 0x00.
- Wrap:
  - Stimulus: cursor_set 0xFF, send 'Z'.
  - Required: mem[0xFF]=0x5A, cursor_xy=0x00.
- Priority and ignore:
  - Stimulus: cursor_set=1 with wr_valid=1, wr_char='Q', cursor_in=0x10.
  - Required: wr_ready=0, cursor_xy=0x10, no write. 'Q' is written at 0x10 on the following cycle once cursor_set drops.
  - Stimulus: send 0x01.
  - Required: accepted, no change.
- Form feed mid-stream:
  - Stimulus: fill cells 0..3, send FF, then assert wr_valid immediately.
  - Required: busy=1 for 256 cycles, char not accepted until IDLE, all cells read 0x20, cursor_xy=0x00.
  - Stimulus: assert rst at clear cycle 100.
  - Required: the clear restarts, giving 256 further busy cycles.
